// File: rtl/decoder_pkg.sv
// Shared encodings for the registered one-hot decoder: output modes and FSM states.
package decoder_pkg;

    typedef enum logic [1:0] {
        MODE_LEVEL   = 2'b00,
        MODE_PULSE   = 2'b01,
        MODE_STICKY  = 2'b10,
        MODE_STRETCH = 2'b11
    } mode_t;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_STRETCH = 1'b1
    } state_t;

endpackage

// File: rtl/onehot_dec.sv
// Combinational binary-to-one-hot decode; in_range is low when the code has no output bit.
module onehot_dec #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 8
) (
    input  logic [IN_W-1:0]  code,
    output logic [OUT_W-1:0] onehot,
    output logic             in_range
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < OUT_W; i++) begin
            onehot[i] = (code == IN_W'(i));
        end
    end

    // A code lands on exactly one bit when it is below OUT_W, otherwise on none.
    assign in_range = |onehot;

endmodule

// File: rtl/sync_onehot_decoder.sv
// Registered one-hot decoder with valid/ready input and LEVEL/PULSE/STICKY/STRETCH output modes.
// Handshake: a code is taken on any rising edge where in_valid && in_ready; in_ready is low only while stretching.
module sync_onehot_decoder
    import decoder_pkg::*;
#(
    parameter int IN_W     = 3,
    parameter int OUT_W    = 8,
    parameter int HOLD_CYC = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_code,
    input  logic [1:0]       mode,
    input  logic             clr,
    output logic [OUT_W-1:0] out,
    output logic             out_valid,
    output logic             err,
    output logic             err_flag
);

    localparam int CNT_W = $clog2(HOLD_CYC + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);

    state_t            state;
    state_t            state_nxt;
    mode_t             mode_q;
    mode_t             mode_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [OUT_W-1:0]  base;
    logic [OUT_W-1:0]  out_nxt;
    logic              err_nxt;
    logic              err_flag_nxt;
    logic              accept;
    logic [OUT_W-1:0]  dec_onehot;
    logic              dec_in_range;

    onehot_dec #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_dec (
        .code     (in_code),
        .onehot   (dec_onehot),
        .in_range (dec_in_range)
    );

    assign in_ready = (state == ST_IDLE);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mode_q    <= MODE_LEVEL;
            cnt       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            err_flag  <= 1'b0;
        end else begin
            state     <= state_nxt;
            mode_q    <= mode_nxt;
            cnt       <= cnt_nxt;
            out       <= out_nxt;
            out_valid <= accept;
            err       <= err_nxt;
            err_flag  <= err_flag_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        mode_nxt     = mode_q;
        cnt_nxt      = cnt;
        base         = out;
        err_flag_nxt = err_flag;
        err_nxt      = 1'b0;

        // Base is what out becomes with no accept this cycle.
        case (state)
            ST_STRETCH: begin
                if (cnt == '0) begin
                    base      = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                if (mode_q == MODE_PULSE) begin
                    base = '0;
                end
            end
        endcase

        // Clear wins over the hold, but a same-cycle accept still lands on top of it.
        if (clr) begin
            base         = '0;
            state_nxt    = ST_IDLE;
            cnt_nxt      = '0;
            err_flag_nxt = 1'b0;
        end

        out_nxt = base;

        if (accept) begin
            mode_nxt = mode_t'(mode);
            if (dec_in_range) begin
                case (mode_t'(mode))
                    MODE_STICKY: out_nxt = base | dec_onehot;
                    MODE_STRETCH: begin
                        out_nxt   = dec_onehot;
                        state_nxt = ST_STRETCH;
                        cnt_nxt   = HOLD_LOAD;
                    end
                    default: out_nxt = dec_onehot;
                endcase
            end else begin
                err_nxt      = 1'b1;
                err_flag_nxt = 1'b1;
            end
        end
    end

endmodule
